// File: rtl/rggen_irq_vector_controller.sv
// Interrupt aggregator: masks status with enable, coalesces bursts with a holdoff
// delay, then raises a registered request carrying the lowest pending source index.
module rggen_irq_vector_controller #(
  parameter int TOTAL_INTERRUPTS = 8,
  parameter int ID_WIDTH         = (TOTAL_INTERRUPTS > 1) ? $clog2(TOTAL_INTERRUPTS) : 1,
  parameter int HOLDOFF_WIDTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_enable,
  input  logic [TOTAL_INTERRUPTS-1:0] i_ier,
  input  logic [TOTAL_INTERRUPTS-1:0] i_isr,
  input  logic [HOLDOFF_WIDTH-1:0]    i_holdoff,
  input  logic                        i_ack,
  output logic                        o_irq,
  output logic [ID_WIDTH-1:0]         o_irq_id,
  output logic [TOTAL_INTERRUPTS-1:0] o_pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLDOFF = 2'd1,
    ASSERT  = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [HOLDOFF_WIDTH-1:0]    cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]         id_q, id_d;
  logic                        irq_q, irq_d;
  logic [TOTAL_INTERRUPTS-1:0] pending_q;

  logic [TOTAL_INTERRUPTS-1:0] pending;
  logic                        any;
  logic [ID_WIDTH-1:0]         winner;
  logic                        latch_id;

  assign pending = i_ier & i_isr;
  assign any     = |pending;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = TOTAL_INTERRUPTS - 1; i >= 0; i--) begin
      if (pending[i]) winner = ID_WIDTH'(i);
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_id = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          if (i_holdoff == '0) begin
            state_d  = ASSERT;
            latch_id = 1'b1;
          end else begin
            cnt_d   = i_holdoff;
            state_d = HOLDOFF;
          end
        end
      end
      HOLDOFF: begin
        if (!any) begin
          state_d = IDLE;
        end else if (cnt_q == HOLDOFF_WIDTH'(1)) begin
          state_d  = ASSERT;
          latch_id = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLDOFF_WIDTH'(1);
        end
      end
      ASSERT: begin
        if (i_ack || !any) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!i_enable) begin
      state_d  = IDLE;
      latch_id = 1'b0;
    end
  end

  assign id_d  = latch_id ? winner : id_q;
  assign irq_d = (state_d == ASSERT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      id_q      <= '0;
      irq_q     <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      irq_q     <= irq_d;
      pending_q <= pending;
    end
  end

  assign o_irq     = irq_q;
  assign o_irq_id  = id_q;
  assign o_pending = pending_q;

endmodule

// File: tb/tb_rggen_irq_vector_controller.sv
// Directed bench for rggen_irq_vector_controller: each step drives inputs just
// after a rising edge and checks outputs against hand-computed values.
module tb_rggen_irq_vector_controller;

  logic       clk;
  logic       rst_n;
  logic       i_enable;
  logic [7:0] i_ier;
  logic [7:0] i_isr;
  logic [7:0] i_holdoff;
  logic       i_ack;
  logic       o_irq;
  logic [2:0] o_irq_id;
  logic [7:0] o_pending;

  int checks   = 0;
  int failures = 0;

  rggen_irq_vector_controller #(
    .TOTAL_INTERRUPTS(8),
    .HOLDOFF_WIDTH   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (i_enable),
    .i_ier    (i_ier),
    .i_isr    (i_isr),
    .i_holdoff(i_holdoff),
    .i_ack    (i_ack),
    .o_irq    (o_irq),
    .o_irq_id (o_irq_id),
    .o_pending(o_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs and samples live here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    i_enable  = 1'b0;
    i_ier     = 8'h00;
    i_isr     = 8'h00;
    i_holdoff = 8'd0;
    i_ack     = 1'b0;
    #12;
    check("rst_irq",     32'(o_irq),     32'h0);
    check("rst_id",      32'(o_irq_id),  32'h0);
    check("rst_pending", 32'(o_pending), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Holdoff 0: request one cycle after pending, ack, re-assert.
    i_enable = 1'b1;
    i_ier    = 8'hFF;
    i_isr    = 8'h28;
    tick();
    check("h0_irq",     32'(o_irq),     32'h1);
    check("h0_id",      32'(o_irq_id),  32'h3);
    check("h0_pending", 32'(o_pending), 32'h28);
    tick();
    check("h0_hold", 32'(o_irq), 32'h1);
    tick();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("h0_ack_low", 32'(o_irq), 32'h0);
    tick();
    check("h0_reassert",    32'(o_irq),    32'h1);
    check("h0_reassert_id", 32'(o_irq_id), 32'h3);
    i_isr = 8'h00;
    tick();
    check("withdraw_low", 32'(o_irq), 32'h0);

    // Holdoff 4: request rises on the fifth edge.
    i_holdoff = 8'd4;
    i_isr     = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("h4_wait%0d", i), 32'(o_irq), 32'h0);
    end
    tick();
    check("h4_irq", 32'(o_irq),    32'h1);
    check("h4_id",  32'(o_irq_id), 32'h0);
    i_isr = 8'h00;
    tick();
    check("h4_withdraw", 32'(o_irq), 32'h0);

    // Burst withdrawn mid-holdoff: FSM back in IDLE at t+3, so holdoff 0 fires at t+4.
    i_isr = 8'h01;
    tick();
    tick();
    i_isr = 8'h00;
    tick();
    check("burst_quiet", 32'(o_irq), 32'h0);
    i_holdoff = 8'd0;
    i_isr     = 8'h01;
    tick();
    check("burst_idle_then_assert", 32'(o_irq), 32'h1);
    i_isr = 8'h00;
    tick();

    // ID frozen while asserted; new winner after ack.
    i_isr = 8'h20;
    tick();
    check("frz_irq", 32'(o_irq),    32'h1);
    check("frz_id5", 32'(o_irq_id), 32'h5);
    i_isr = 8'h22;
    tick();
    check("frz_id_held", 32'(o_irq_id), 32'h5);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("frz_ack_low", 32'(o_irq), 32'h0);
    tick();
    check("frz_reassert", 32'(o_irq),    32'h1);
    check("frz_new_id",   32'(o_irq_id), 32'h1);
    i_isr = 8'h00;
    tick();

    // Masking by i_ier.
    i_ier = 8'h00;
    i_isr = 8'hFF;
    tick();
    tick();
    check("mask_irq",     32'(o_irq),     32'h0);
    check("mask_pending", 32'(o_pending), 32'h00);
    i_ier = 8'h80;
    tick();
    check("ier80_irq",     32'(o_irq),     32'h1);
    check("ier80_id",      32'(o_irq_id),  32'h7);
    check("ier80_pending", 32'(o_pending), 32'h80);

    // Ack and withdrawal together, then ack while idle.
    i_isr = 8'h00;
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("ackwd_low", 32'(o_irq), 32'h0);
    tick();
    check("ackwd_stay_low", 32'(o_irq),    32'h0);
    check("id_kept_idle",   32'(o_irq_id), 32'h7);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    tick();
    check("idle_ack_noeffect", 32'(o_irq), 32'h0);

    // Global enable drop.
    i_ier = 8'hFF;
    i_isr = 8'h08;
    tick();
    check("en_irq", 32'(o_irq),    32'h1);
    check("en_id",  32'(o_irq_id), 32'h3);
    i_enable = 1'b0;
    tick();
    check("dis_irq",     32'(o_irq),     32'h0);
    check("dis_pending", 32'(o_pending), 32'h08);
    tick();
    check("dis_irq_stay", 32'(o_irq), 32'h0);
    i_enable = 1'b1;
    tick();
    check("reen_irq", 32'(o_irq), 32'h1);
    i_isr = 8'h00;
    tick();

    // Asynchronous reset mid-HOLDOFF.
    i_holdoff = 8'd4;
    i_isr     = 8'h04;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_hold_irq",     32'(o_irq),     32'h0);
    check("rst_hold_id",      32'(o_irq_id),  32'h0);
    check("rst_hold_pending", 32'(o_pending), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("restart_wait%0d", i), 32'(o_irq), 32'h0);
    end
    tick();
    check("restart_irq", 32'(o_irq),    32'h1);
    check("restart_id",  32'(o_irq_id), 32'h2);

    // Asynchronous reset mid-ASSERT.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_asrt_irq",     32'(o_irq),     32'h0);
    check("rst_asrt_id",      32'(o_irq_id),  32'h0);
    check("rst_asrt_pending", 32'(o_pending), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
